// File: rtl/mbox_pkg.sv
// rtl/mbox_pkg.sv - shared mailbox constants, entry type and status helper (MBOX_SENDER_ID_EN)
package mbox_pkg;

  localparam int NHARTS_DEF = 4;
  localparam int DEPTH_DEF  = 4;
  localparam int DW_DEF     = 32;
  localparam int SRC_W      = 2;

  // Status word layout
  localparam int ST_COUNT = 0;
  localparam int ST_FULL  = 4;
  localparam int ST_OVF   = 5;
  localparam int ST_SRC   = 6;
  localparam int ST_W     = 8;

`ifdef MBOX_SENDER_ID_EN
  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DW_DEF-1:0] data;
  } mbox_entry_t;
`else
  typedef struct packed {
    logic [DW_DEF-1:0] data;
  } mbox_entry_t;
`endif

  // Assemble the status word; bits above the defined fields read 0
  function automatic logic [ST_W-1:0] status_word(
    input logic [3:0]       count,
    input logic             full,
    input logic             ovf,
    input logic [SRC_W-1:0] src
  );
    logic [ST_W-1:0] w;
    w                    = '0;
    w[ST_COUNT +: 4]     = count;
    w[ST_FULL]           = full;
    w[ST_OVF]            = ovf;
    w[ST_SRC +: SRC_W]   = src;
    return w;
  endfunction

endpackage

// File: rtl/mbox_fifo.sv
// rtl/mbox_fifo.sv - one mailbox: entry storage, pointers, count and sticky overflow
module mbox_fifo
  import mbox_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       push,
  input  mbox_entry_t                push_entry,
  input  logic                       pop,
  input  logic                       clr_ovf,
  output mbox_entry_t                head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  mbox_entry_t   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          ovf_q;
  logic          pop_ok;
  logic          push_ok;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign ovf   = ovf_q;
  assign head  = mem[rptr];

  // A pop frees the slot this cycle, so a full mailbox still accepts a concurrent push
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Entry storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= push_entry;
    end
  end

  // Pointers, occupancy and sticky overflow; a new overflow beats a same-cycle clear
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (push && !push_ok) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mbox_reader.sv
// rtl/mbox_reader.sv - per-hart mailbox receive block serving MEM-stage loads (MBOX_SENDER_ID_EN)
module mbox_reader
  import mbox_pkg::*;
#(
  parameter int NHARTS = NHARTS_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              wr_en,
  input  logic [1:0]        wr_dst,
  input  logic [1:0]        wr_src,
  input  logic [DW-1:0]     wr_data,
  output logic [NHARTS-1:0] mbox_full,
  input  logic              rd_req,
  input  logic [1:0]        rd_hart,
  input  logic              rd_status,
  output logic              rd_stall,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data,
  output logic [NHARTS-1:0] mbox_nonempty
);

  localparam int CW = $clog2(DEPTH) + 1;

  mbox_entry_t       wr_entry;
  mbox_entry_t       head [NHARTS];
  logic [CW-1:0]     cnt  [NHARTS];
  logic [NHARTS-1:0] full;
  logic [NHARTS-1:0] empty;
  logic [NHARTS-1:0] ovf;
  logic [NHARTS-1:0] push;
  logic [NHARTS-1:0] pop;
  logic [NHARTS-1:0] clr;
  logic              data_load;
  logic              stat_load;
  logic              sel_empty;
  logic [SRC_W-1:0]  st_src;
  logic [ST_W-1:0]   st_word;

  // Pack the incoming store into a mailbox entry
  always_comb begin
    wr_entry      = '0;
    wr_entry.data = wr_data;
`ifdef MBOX_SENDER_ID_EN
    wr_entry.src  = wr_src;
`endif
  end

`ifndef MBOX_SENDER_ID_EN
  logic unused_src;
  assign unused_src = ^wr_src;
`endif

  assign data_load = rd_req && !rd_status;
  assign stat_load = rd_req && rd_status;
  assign sel_empty = empty[rd_hart];

  for (genvar h = 0; h < NHARTS; h++) begin : g_mbox
    assign push[h] = wr_en && (wr_dst == 2'(h));
    assign pop[h]  = data_load && (rd_hart == 2'(h)) && !empty[h];
    assign clr[h]  = stat_load && (rd_hart == 2'(h));

    mbox_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk       (clk),
      .Reset     (Reset),
      .push      (push[h]),
      .push_entry(wr_entry),
      .pop       (pop[h]),
      .clr_ovf   (clr[h]),
      .head      (head[h]),
      .count     (cnt[h]),
      .full      (full[h]),
      .empty     (empty[h]),
      .ovf       (ovf[h])
    );
  end

  assign mbox_full     = full;
  assign mbox_nonempty = ~empty;

  // No bypass: an empty mailbox stalls a data load even if a push lands this cycle
  assign rd_stall = !Reset && data_load && sel_empty;

  // Status word of the requesting hart's mailbox
  always_comb begin
    st_src = '0;
`ifdef MBOX_SENDER_ID_EN
    if (!empty[rd_hart]) begin
      st_src = head[rd_hart].src;
    end
`endif
    st_word = status_word(4'(cnt[rd_hart]), full[rd_hart], ovf[rd_hart], st_src);
  end

  // One-cycle load response; rd_data holds its value between responses
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= stat_load || (data_load && !sel_empty);
      if (stat_load) begin
        rd_data <= DW'(st_word);
      end else if (data_load && !sel_empty) begin
        rd_data <= head[rd_hart].data;
      end
    end
  end

endmodule
